imem_boot_loader: RTL and testbench

Upstream of the single-cycle core, this block loads a program into the instruction memory from a byte stream before the core runs. It holds the core in reset and accepts a framed byte stream: a 16-bit length, then the data words, then a checksum. It packs the bytes into little-endian 32-bit words and writes them to the instruction memory write port at consecutive byte addresses from 0. It releases the core only after the checksum verifies.

---
 rtl/imem_boot_loader_pkg.sv | 19 +
 rtl/imem_boot_loader_if.sv | 23 ++
 rtl/imem_boot_loader_byte_word_packer.sv | 48 ++++
 rtl/imem_boot_loader.sv | 141 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the loader state encoding and the frame/word geometry.
// Imported by the packer and the top-level loader.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// slave: the loader side; master: the stream source / memory side.
// byte_ready is the only signal flowing back toward the stream source.
interface imem_boot_loader_if;

    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport slave (
        input  byte_data, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output byte_data, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Packs accepted bytes into little-endian words (first byte in bits 7:0).
// Latency: word_o/word_done_o are combinational in the cycle of the last lane's byte.
// No backpressure: every asserted accept_i consumes byte_i.
module byte_word_packer
    import boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_i,
    input  logic        accept_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    localparam int LANE_W = $clog2(BYTES_PER_WORD);
    localparam int SH_W   = (BYTES_PER_WORD - 1) * 8;

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [SH_W-1:0]   shift_q, shift_d;
    logic              last_lane;

    assign last_lane   = (lane_q == LANE_W'(BYTES_PER_WORD - 1));
    // Earlier bytes sit in the low bits; the current byte completes the top lane.
    assign word_o      = {byte_i, shift_q};
    assign word_done_o = accept_i && last_lane;

    // Advance the lane and shift the byte in from the top on every accept.
    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        if (accept_i) begin
            shift_d = {byte_i, shift_q[SH_W-1:8]};
            lane_d  = last_lane ? '0 : lane_q + 1'b1;
        end
    end

    // Lane counter and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a framed byte stream (len, words, xor checksum) into instruction memory, holding the core in reset.
// Latency: write strobe/addr/data registered, one cycle after the 4th byte of a word.
// Backpressure: byte_ready low outside LEN_LO/LEN_HI/DATA/CSUM; bytes offered then are dropped.
module imem_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    imem_boot_loader_if.slave   bus,
    output logic                core_rst,
    output logic                load_done,
    output logic                load_error
);

    localparam int IDX_W = $clog2(DEPTH) + 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         acc_q, acc_d;
    logic [7:0]         len_lo_q, len_lo_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic               accept;
    logic               data_accept;
    logic [31:0]        word;
    logic               word_done;
    logic [LEN_W-1:0]   len_full;
    logic [IDX_W-1:0]   idx_next;
    logic               last_word;

    assign accept      = bus.byte_valid && bus.byte_ready;
    assign data_accept = accept && (state_q == DATA);
    assign len_full    = {bus.byte_data, len_lo_q};
    assign idx_next    = idx_q + 1'b1;
    assign last_word   = (LEN_W'(idx_next) == len_q);

    byte_word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .byte_i      (bus.byte_data),
        .accept_i    (data_accept),
        .word_o      (word),
        .word_done_o (word_done)
    );

    // Next state, counters, checksum accumulator and write-port staging.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: state_d = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    len_lo_d = bus.byte_data;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full > LEN_W'(DEPTH)) begin
                        state_d = ERROR;
                    end else if (len_full == '0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    acc_d = acc_q ^ bus.byte_data;
                    if (word_done) begin
                        we_d    = 1'b1;
                        addr_d  = {{(32 - IDX_W - 2){1'b0}}, idx_q, 2'b00};
                        wdata_d = word;
                        idx_d   = idx_next;
                        if (last_word) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    state_d = (bus.byte_data == acc_q) ? DONE : ERROR;
                end
            end
            DONE, ERROR: state_d = state_q;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any load in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            len_lo_q <= '0;
            len_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Status and handshake outputs decoded from the registered state.
    always_comb begin
        bus.byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                         (state_q == DATA)   || (state_q == CSUM);
        core_rst       = (state_q != DONE);
        load_done      = (state_q == DONE);
        load_error     = (state_q == ERROR);
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: frames are driven byte by byte and scored
// against a frame-level model (length, little-endian words, xor checksum).
module tb_imem_boot_loader;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic core_rst, load_done, load_error;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    imem_boot_loader_if bus ();

    imem_boot_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .core_rst   (core_rst),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed writes (cycle seen, address, data).
    int          wr_cyc[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    // Frame under test and the cycle at which each of its bytes was accepted.
    logic [7:0]  fr[$];
    int          acc_cyc[$];

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
    end

    task automatic clear_logs();
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        acc_cyc.delete();
    endtask

    task automatic do_reset();
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clear_logs();
        rst = 1'b0;
    endtask

    // Offer one byte after an idle gap; returns once it has been accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        logic r;
        ok = 1'b0;
        bus.byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            r = bus.byte_ready;
            @(posedge clk);
            #1;
            if (r === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) acc_cyc.push_back(cyc);
    endtask

    function automatic int frame_len();
        return int'(fr[0]) | (int'(fr[1]) << 8);
    endfunction

    // Bytes the loader should consume: an oversize length stops after LEN_HI.
    function automatic int frame_bytes();
        int n = frame_len();
        return (n > DEPTH) ? 2 : 2 + 4 * n + 1;
    endfunction

    task automatic drive_frame(input string name, input int nbytes, input int max_gap);
        bit ok;
        for (int i = 0; i < nbytes; i++) begin
            send_byte(fr[i], $urandom_range(0, max_gap), ok);
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL %s: byte %0d not accepted within 20 cycles", name, i);
                break;
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    // Random frame of n words; the checksum is corrupted when asked to.
    task automatic build_frame(input int n, input bit corrupt);
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        fr.delete();
        fr.push_back(n[7:0]);
        fr.push_back(n[15:8]);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            x ^= b;
            fr.push_back(b);
        end
        fr.push_back(corrupt ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
    endtask

    // Called right after drive_frame of the full frame: scores status then writes.
    task automatic score_frame(input string name);
        int          n   = frame_len();
        int          nw;
        logic [7:0]  x   = 8'h00;
        bit          exp_done;
        logic [31:0] w;
        int          ncmp;

        if (n > DEPTH) begin
            nw       = 0;
            exp_done = 1'b0;
        end else begin
            nw = n;
            for (int i = 0; i < 4 * n; i++) x ^= fr[2 + i];
            exp_done = (fr[2 + 4 * n] == x);
        end

        @(negedge clk);
        total++;
        if (load_done !== exp_done) begin
            bad++;
            $display("FAIL %s load_done: got %b want %b", name, load_done, exp_done);
        end
        total++;
        if (load_error !== !exp_done) begin
            bad++;
            $display("FAIL %s load_error: got %b want %b", name, load_error, !exp_done);
        end
        total++;
        if (core_rst !== !exp_done) begin
            bad++;
            $display("FAIL %s core_rst: got %b want %b", name, core_rst, !exp_done);
        end
        total++;
        if (bus.byte_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s byte_ready after end: got %b want 0", name, bus.byte_ready);
        end

        repeat (4) @(negedge clk);
        total++;
        if (wr_cyc.size() != nw) begin
            bad++;
            $display("FAIL %s write count: got %0d want %0d", name, wr_cyc.size(), nw);
        end
        ncmp = (wr_cyc.size() < nw) ? wr_cyc.size() : nw;
        for (int i = 0; i < ncmp; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) w |= 32'(fr[2 + 4 * i + k]) << (8 * k);
            total++;
            if (wr_addr[i] !== 32'(4 * i)) begin
                bad++;
                $display("FAIL %s addr[%0d]: got %h want %h", name, i, wr_addr[i], 32'(4 * i));
            end
            total++;
            if (wr_data[i] !== w) begin
                bad++;
                $display("FAIL %s data[%0d]: got %h want %h", name, i, wr_data[i], w);
            end
            total++;
            if (acc_cyc.size() > 5 + 4 * i && wr_cyc[i] != acc_cyc[5 + 4 * i]) begin
                bad++;
                $display("FAIL %s timing[%0d]: write cycle %0d want %0d", name, i, wr_cyc[i], acc_cyc[5 + 4 * i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h5A;
        repeat (3) @(negedge clk);
        total++;
        if (bus.byte_ready !== 1'b0 || bus.imem_we !== 1'b0) begin
            bad++;
            $display("FAIL reset ready/we: got %b/%b want 0/0", bus.byte_ready, bus.imem_we);
        end
        total++;
        if (bus.imem_addr !== 32'h0 || bus.imem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset addr/wdata: got %h/%h want 0/0", bus.imem_addr, bus.imem_wdata);
        end
        total++;
        if (core_rst !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0) begin
            bad++;
            $display("FAIL reset status: core_rst/done/err got %b/%b/%b want 1/0/0", core_rst, load_done, load_error);
        end
        bus.byte_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        @(negedge clk);
        total++;
        if (bus.byte_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset ready before first edge: got %b want 0", bus.byte_ready);
        end
        @(negedge clk);
        total++;
        if (bus.byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset ready one cycle after release: got %b want 1", bus.byte_ready);
        end
    endtask

    // Words 0x00000013 and 0x00A00093; the xor of their bytes is 0x20.
    task automatic load_two_words(input logic [7:0] csum);
        fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'hA0, 8'h00, csum};
    endtask

    task automatic test_good_frame();
        do_reset();
        load_two_words(8'h20);
        drive_frame("good", frame_bytes(), 0);
        score_frame("good");
    endtask

    task automatic test_bad_csum();
        do_reset();
        load_two_words(8'h00);
        drive_frame("bad_csum", frame_bytes(), 0);
        score_frame("bad_csum");
    endtask

    task automatic test_len_overflow();
        do_reset();
        fr = '{8'h41, 8'h00};
        drive_frame("overflow", 2, 0);
        score_frame("overflow");
        bus.byte_data  = 8'hAA;
        bus.byte_valid = 1'b1;
        repeat (5) @(negedge clk);
        bus.byte_valid = 1'b0;
        total++;
        if (bus.byte_ready !== 1'b0 || wr_cyc.size() != 0 || load_error !== 1'b1) begin
            bad++;
            $display("FAIL overflow sticky: ready=%b writes=%0d err=%b want 0/0/1", bus.byte_ready, wr_cyc.size(), load_error);
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        fr = '{8'h00, 8'h00, 8'h00};
        drive_frame("zero_len", frame_bytes(), 0);
        score_frame("zero_len");
    endtask

    task automatic test_gaps();
        do_reset();
        build_frame(1, 1'b0);
        drive_frame("gaps", frame_bytes(), 4);
        score_frame("gaps");
    endtask

    task automatic test_mid_reset();
        do_reset();
        build_frame(3, 1'b0);
        drive_frame("mid_rst_pre", 8, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (core_rst !== 1'b1 || bus.byte_ready !== 1'b0 || bus.imem_we !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst abort: core_rst/ready/we got %b/%b/%b want 1/0/0", core_rst, bus.byte_ready, bus.imem_we);
        end
        total++;
        if (wr_cyc.size() != 1) begin
            bad++;
            $display("FAIL mid_rst pre-writes: got %0d want 1", wr_cyc.size());
        end
        do_reset();
        build_frame(1, 1'b0);
        drive_frame("mid_rst_post", frame_bytes(), 1);
        score_frame("mid_rst_post");
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 5; t++) begin
            do_reset();
            n = (t == 0) ? DEPTH : $urandom_range(1, 6);
            build_frame(n, ($urandom_range(0, 3) == 0));
            drive_frame("random", frame_bytes(), 2);
            score_frame($sformatf("random%0d_n%0d", t, n));
        end
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_len_overflow();
        test_zero_len();
        test_gaps();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
